// File: rtl/conv_layer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// conv_layer_sequencer_pkg
// Shared definitions for the two-layer 1-D CNN sequencer: default geometry,
// FSM state encoding and the per-layer length helpers.
// ---------------------------------------------------------------------------
package conv_layer_sequencer_pkg;

    localparam int DATANUM_DEF    = 32'd15;
    localparam int TAPS_DEF       = 32'd3;
    localparam int NUM_LAYERS_DEF = 32'd2;
    localparam int PIPE_LAT_DEF   = 32'd2;
    localparam int LAYER_W_DEF    = (NUM_LAYERS_DEF > 32'd1) ? $clog2(NUM_LAYERS_DEF) : 32'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CONV  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    // Samples loaded for a layer: each previous layer shrank the stream by taps-1.
    function automatic int unsigned layer_load_len(input int unsigned datanum,
                                                   input int unsigned taps,
                                                   input int unsigned layer);
        return datanum - (taps - 32'd1) * layer;
    endfunction

    // Number of full windows that fit in the loaded samples of a layer.
    function automatic int unsigned layer_win_len(input int unsigned datanum,
                                                  input int unsigned taps,
                                                  input int unsigned layer);
        return layer_load_len(datanum, taps, layer) - (taps - 32'd1);
    endfunction

endpackage

// File: rtl/conv_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// conv_layer_sequencer_if
// Control/handshake bundle between the sequencer and its environment.
//   start_i, abort_i      run control (from environment)
//   in_valid / in_ready   input sample handshake
//   rf_we, cnt_start      register-file write and write-counter start
//   read_en, addr_clr     read-counter enable and counter clear
//   out_valid             MAC result valid
//   layer_idx, busy, done status
// master: environment side, slave: sequencer side.
// ---------------------------------------------------------------------------
interface conv_layer_sequencer_if
    import conv_layer_sequencer_pkg::*;
#(
    parameter int LAYER_W = LAYER_W_DEF
);
    logic               start_i;
    logic               abort_i;
    logic               in_valid;
    logic               in_ready;
    logic               rf_we;
    logic               cnt_start;
    logic               read_en;
    logic               addr_clr;
    logic               out_valid;
    logic [LAYER_W-1:0] layer_idx;
    logic               busy;
    logic               done;

    modport master (
        output start_i, abort_i, in_valid,
        input  in_ready, rf_we, cnt_start, read_en, addr_clr,
               out_valid, layer_idx, busy, done
    );

    modport slave (
        input  start_i, abort_i, in_valid,
        output in_ready, rf_we, cnt_start, read_en, addr_clr,
               out_valid, layer_idx, busy, done
    );
endinterface

// File: rtl/conv_layer_sequencer_valid_delay_line.sv
// ---------------------------------------------------------------------------
// valid_delay_line
// Shift register that turns read_en into the MAC result valid, PIPE_LAT
// cycles later. A synchronous flush empties it so no stale result is flagged
// after an abort.
//   clk, rst   clock, asynchronous active-high reset
//   flush      synchronous clear of all stages
//   din        read_en of the current cycle
//   dout       din delayed by PIPE_LAT cycles (registered)
// ---------------------------------------------------------------------------
module valid_delay_line #(
    parameter int PIPE_LAT = 32'd2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic din,
    output logic dout
);
    logic [PIPE_LAT-1:0] shift_r;

    // delay stages, flush wins over shifting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= {PIPE_LAT{1'b0}};
        end else if (flush) begin
            shift_r <= {PIPE_LAT{1'b0}};
        end else begin
            shift_r[0] <= din;
            for (int i = 1; i < PIPE_LAT; i++) begin
                shift_r[i] <= shift_r[i-1];
            end
        end
    end

    assign dout = shift_r[PIPE_LAT-1];
endmodule

// File: rtl/conv_layer_sequencer.sv
// ---------------------------------------------------------------------------
// conv_layer_sequencer
// Top-level sequencer of the two-layer 1-D CNN datapath. Per layer it clears
// the address counters, loads the layer's input samples into the register
// file, sweeps one TAPS-wide window per cycle and waits for the MAC pipeline
// to drain before moving on to the next layer.
//   clk    clock, rising edge
//   rst_n  asynchronous reset, active HIGH (name kept for the codebase)
//   bus    conv_layer_sequencer_if.slave control/handshake bundle
// ---------------------------------------------------------------------------
module conv_layer_sequencer
    import conv_layer_sequencer_pkg::*;
#(
    parameter int DATANUM    = DATANUM_DEF,
    parameter int TAPS       = TAPS_DEF,
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    conv_layer_sequencer_if.slave bus
);
    localparam int CNT_W   = $clog2(DATANUM + 32'd1);
    localparam int LAYER_W = (NUM_LAYERS > 32'd1) ? $clog2(NUM_LAYERS) : 32'd1;

    seq_state_t         state_r, state_s;
    logic [CNT_W-1:0]   load_cnt_r, load_cnt_s;
    logic [CNT_W-1:0]   step_cnt_r, step_cnt_s;
    logic [LAYER_W-1:0] layer_r, layer_s;
    logic [CNT_W-1:0]   load_last_s, win_last_s;

    logic in_ready_r, in_ready_s;
    logic read_en_r, read_en_s;
    logic addr_clr_r, addr_clr_s;
    logic busy_r, busy_s;
    logic done_r, done_s;
    logic rf_we_s;
    logic out_valid_s;

    // Last count values for the current layer; the counters only ever run
    // up to these, so no address counter wraps inside a layer.
    assign load_last_s = CNT_W'(layer_load_len(DATANUM, TAPS, 32'(layer_r)) - 32'd1);
    assign win_last_s  = CNT_W'(layer_win_len(DATANUM, TAPS, 32'(layer_r)) - 32'd1);

    // A sample is written only when it is offered while loading.
    assign rf_we_s = bus.in_valid & in_ready_r;

    // next-state, counter and output decode
    always_comb begin
        state_s    = state_r;
        load_cnt_s = load_cnt_r;
        step_cnt_s = step_cnt_r;
        layer_s    = layer_r;

        if (bus.abort_i) begin
            state_s    = ST_IDLE;
            load_cnt_s = {CNT_W{1'b0}};
            step_cnt_s = {CNT_W{1'b0}};
            layer_s    = {LAYER_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state_s = ST_CLR;
                        layer_s = {LAYER_W{1'b0}};
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_CLR: begin
                    state_s    = ST_LOAD;
                    load_cnt_s = {CNT_W{1'b0}};
                end
                ST_LOAD: begin
                    if (rf_we_s) begin
                        if (load_cnt_r == load_last_s) begin
                            state_s    = ST_CONV;
                            load_cnt_s = {CNT_W{1'b0}};
                            step_cnt_s = {CNT_W{1'b0}};
                        end else begin
                            load_cnt_s = load_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_s = ST_LOAD;
                    end
                end
                ST_CONV: begin
                    if (step_cnt_r == win_last_s) begin
                        state_s    = ST_DRAIN;
                        step_cnt_s = {CNT_W{1'b0}};
                    end else begin
                        step_cnt_s = step_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DRAIN: begin
                    // the last window's result is flagged in the final drain cycle
                    if (step_cnt_r == CNT_W'(PIPE_LAT - 32'd1)) begin
                        step_cnt_s = {CNT_W{1'b0}};
                        if (layer_r < LAYER_W'(NUM_LAYERS - 32'd1)) begin
                            state_s = ST_CLR;
                            layer_s = layer_r + {{(LAYER_W-1){1'b0}}, 1'b1};
                        end else begin
                            state_s = ST_DONE;
                        end
                    end else begin
                        step_cnt_s = step_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    // layer_idx reads 0 whenever the sequencer is idle
                    state_s = ST_IDLE;
                    layer_s = {LAYER_W{1'b0}};
                end
                default: begin
                    state_s    = ST_IDLE;
                    load_cnt_s = {CNT_W{1'b0}};
                    step_cnt_s = {CNT_W{1'b0}};
                    layer_s    = {LAYER_W{1'b0}};
                end
            endcase
        end

        // outputs are decoded from the next state so they can be registered
        in_ready_s = (state_s == ST_LOAD);
        read_en_s  = (state_s == ST_CONV);
        addr_clr_s = (state_s == ST_CLR);
        busy_s     = (state_s != ST_IDLE);
        done_s     = (state_s == ST_DONE);
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r    <= ST_IDLE;
            load_cnt_r <= {CNT_W{1'b0}};
            step_cnt_r <= {CNT_W{1'b0}};
            layer_r    <= {LAYER_W{1'b0}};
            in_ready_r <= 1'b0;
            read_en_r  <= 1'b0;
            addr_clr_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            load_cnt_r <= load_cnt_s;
            step_cnt_r <= step_cnt_s;
            layer_r    <= layer_s;
            in_ready_r <= in_ready_s;
            read_en_r  <= read_en_s;
            addr_clr_r <= addr_clr_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    valid_delay_line #(
        .PIPE_LAT (PIPE_LAT)
    ) u_valid_delay_line (
        .clk   (clk),
        .rst   (rst_n),
        .flush (bus.abort_i),
        .din   (read_en_r),
        .dout  (out_valid_s)
    );

    assign bus.in_ready  = in_ready_r;
    assign bus.rf_we     = rf_we_s;
    assign bus.cnt_start = rf_we_s;
    assign bus.read_en   = read_en_r;
    assign bus.addr_clr  = addr_clr_r;
    assign bus.out_valid = out_valid_s;
    assign bus.layer_idx = layer_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_layer_sequencer
// Drives three sequencers (PIPE_LAT 2, 1 and 7) with one shared stimulus
// table and compares every output every cycle with a run-level reference
// model, then checks per-scenario event counts against fixed totals.
// ---------------------------------------------------------------------------
module tb_conv_layer_sequencer;
    import conv_layer_sequencer_pkg::*;

    localparam int NCYC  = 700;
    localparam int NB    = NCYC + 16;
    localparam int NV    = 3;
    localparam int NUM_L = 2;

    localparam int PH_IDLE  = 0;
    localparam int PH_CLR   = 1;
    localparam int PH_LOAD  = 2;
    localparam int PH_CONV  = 3;
    localparam int PH_DRAIN = 4;
    localparam int PH_DONE  = 5;

    int lat_tab [NV] = '{2, 1, 7};

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic start    = 1'b0;
    logic abort    = 1'b0;
    logic in_valid = 1'b0;

    bit rst_s   [NB];
    bit start_s [NB];
    bit abort_s [NB];
    bit inv_s   [NB];

    int         phase_m [NV][NB];
    int         layer_m [NV][NB];
    logic [8:0] obs_r   [NV][NB];
    logic [8:0] obs     [NV];

    int checks = 0;
    int errors = 0;

    conv_layer_sequencer_if bus_l2 ();
    conv_layer_sequencer_if bus_l1 ();
    conv_layer_sequencer_if bus_l7 ();

    assign bus_l2.start_i = start;  assign bus_l2.abort_i = abort;  assign bus_l2.in_valid = in_valid;
    assign bus_l1.start_i = start;  assign bus_l1.abort_i = abort;  assign bus_l1.in_valid = in_valid;
    assign bus_l7.start_i = start;  assign bus_l7.abort_i = abort;  assign bus_l7.in_valid = in_valid;

    conv_layer_sequencer #(.PIPE_LAT(2)) dut_l2 (.clk(clk), .rst_n(rst), .bus(bus_l2));
    conv_layer_sequencer #(.PIPE_LAT(1)) dut_l1 (.clk(clk), .rst_n(rst), .bus(bus_l1));
    conv_layer_sequencer #(.PIPE_LAT(7)) dut_l7 (.clk(clk), .rst_n(rst), .bus(bus_l7));

    // bit order: in_ready rf_we cnt_start read_en addr_clr out_valid busy done layer_idx
    assign obs[0] = {bus_l2.in_ready, bus_l2.rf_we, bus_l2.cnt_start, bus_l2.read_en, bus_l2.addr_clr,
                     bus_l2.out_valid, bus_l2.busy, bus_l2.done, bus_l2.layer_idx};
    assign obs[1] = {bus_l1.in_ready, bus_l1.rf_we, bus_l1.cnt_start, bus_l1.read_en, bus_l1.addr_clr,
                     bus_l1.out_valid, bus_l1.busy, bus_l1.done, bus_l1.layer_idx};
    assign obs[2] = {bus_l7.in_ready, bus_l7.rf_we, bus_l7.cnt_start, bus_l7.read_en, bus_l7.addr_clr,
                     bus_l7.out_valid, bus_l7.busy, bus_l7.done, bus_l7.layer_idx};

    // free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Record what a run is doing in cycle c; report whether the run ends there.
    function automatic bit mark(input int v, input int c, input int ph, input int l);
        if (c >= NCYC) return 1'b1;
        phase_m[v][c] = ph;
        layer_m[v][c] = l;
        return rst_s[c] || abort_s[c];
    endfunction

    // Walk the stimulus table run by run: CLR, load N samples, N windows, drain.
    task automatic build_model(input int v);
        int c, got, lat;
        bit stop;
        lat = lat_tab[v];
        for (int i = 0; i < NB; i++) begin
            phase_m[v][i] = PH_IDLE;
            layer_m[v][i] = 0;
        end
        c = 0;
        while (c < NCYC) begin
            if (start_s[c] && !abort_s[c] && !rst_s[c]) begin
                c++;
                stop = 1'b0;
                for (int l = 0; l < NUM_L && !stop; l++) begin
                    stop = mark(v, c, PH_CLR, l);
                    c++;
                    got = 0;
                    while (!stop && got < 15 - 2 * l) begin
                        stop = mark(v, c, PH_LOAD, l);
                        if (inv_s[c]) got++;
                        c++;
                    end
                    for (int i = 0; i < 13 - 2 * l && !stop; i++) begin
                        stop = mark(v, c, PH_CONV, l);
                        c++;
                    end
                    for (int i = 0; i < lat && !stop; i++) begin
                        stop = mark(v, c, PH_DRAIN, l);
                        c++;
                    end
                end
                if (!stop) begin
                    void'(mark(v, c, PH_DONE, NUM_L - 1));
                    c++;
                end
            end else begin
                c++;
            end
        end
    endtask

    // Expected output vector: a window's result shows up lat cycles after it
    // was read unless an abort or reset intervened.
    function automatic logic [8:0] expect_vec(input int v, input int c);
        int   ph, lat;
        logic ov;
        if (rst_s[c]) return 9'd0;
        ph  = phase_m[v][c];
        lat = lat_tab[v];
        ov  = 1'b0;
        if (c >= lat && phase_m[v][c-lat] == PH_CONV) begin
            ov = 1'b1;
            for (int k = c - lat; k <= c; k++) if (rst_s[k]) ov = 1'b0;
            for (int k = c - lat; k < c; k++) if (abort_s[k]) ov = 1'b0;
        end
        return {ph == PH_LOAD, (ph == PH_LOAD) && inv_s[c], (ph == PH_LOAD) && inv_s[c],
                ph == PH_CONV, ph == PH_CLR, ov, ph != PH_IDLE, ph == PH_DONE, 1'(layer_m[v][c])};
    endfunction

    // stimulus table, reference model, cycle loop and scenario totals
    initial begin
        int win_lo [3] = '{10, 150, 330};
        int win_hi [3] = '{150, 330, 370};
        int n_we, n_rd, n_ov, n_clr, n_done, e_ov;

        for (int c = 0; c < NB; c++) begin
            rst_s[c] = 1'b0; start_s[c] = 1'b0; abort_s[c] = 1'b0; inv_s[c] = 1'b0;
        end
        for (int c = 0; c < 4; c++) rst_s[c] = 1'b1;
        // full run, contiguous samples, extra start while in layer-0 CONV
        start_s[10] = 1'b1;
        start_s[30] = 1'b1;
        for (int c = 10; c < 150; c++) inv_s[c] = 1'b1;
        // full run, one sample every 4th cycle
        start_s[150] = 1'b1;
        for (int c = 150; c < 330; c++) inv_s[c] = ((c - 150) % 4 == 0);
        // abort in CONV cycle 5, then start+abort together while idle
        start_s[330] = 1'b1;
        for (int c = 330; c < 370; c++) inv_s[c] = 1'b1;
        abort_s[351] = 1'b1;
        start_s[360] = 1'b1;
        abort_s[360] = 1'b1;
        // reset during layer-1 LOAD
        start_s[370] = 1'b1;
        for (int c = 370; c < 445; c++) inv_s[c] = ((c - 370) % 3 == 0);
        rst_s[445] = 1'b1;
        rst_s[446] = 1'b1;
        // random tail
        for (int c = 450; c < NCYC; c++) begin
            inv_s[c]   = ($urandom_range(0, 3) != 0);
            start_s[c] = ($urandom_range(0, 15) == 0);
            abort_s[c] = ($urandom_range(0, 199) == 0);
        end
        start_s[450] = 1'b1;
        abort_s[450] = 1'b0;

        for (int v = 0; v < NV; v++) build_model(v);

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            rst      = rst_s[c];
            start    = start_s[c];
            abort    = abort_s[c];
            in_valid = inv_s[c];
            @(negedge clk);
            for (int v = 0; v < NV; v++) begin
                obs_r[v][c] = obs[v];
                check($sformatf("cyc%0d_lat%0d", c, lat_tab[v]), 32'(obs[v]), 32'(expect_vec(v, c)));
            end
        end

        for (int s = 0; s < 3; s++) begin
            for (int v = 0; v < NV; v++) begin
                n_we = 0; n_rd = 0; n_ov = 0; n_clr = 0; n_done = 0;
                for (int c = win_lo[s]; c < win_hi[s]; c++) begin
                    n_we   += int'(obs_r[v][c][7]);
                    n_rd   += int'(obs_r[v][c][5]);
                    n_ov   += int'(obs_r[v][c][3]);
                    n_clr  += int'(obs_r[v][c][4]);
                    n_done += int'(obs_r[v][c][1]);
                end
                if (s < 2) begin
                    check($sformatf("seg%0d_lat%0d_writes", s, lat_tab[v]), n_we, 28);
                    check($sformatf("seg%0d_lat%0d_reads", s, lat_tab[v]), n_rd, 24);
                    check($sformatf("seg%0d_lat%0d_results", s, lat_tab[v]), n_ov, 24);
                    check($sformatf("seg%0d_lat%0d_clears", s, lat_tab[v]), n_clr, 2);
                    check($sformatf("seg%0d_lat%0d_done", s, lat_tab[v]), n_done, 1);
                end else begin
                    e_ov = (lat_tab[v] < 5) ? 5 - lat_tab[v] : 0;
                    check($sformatf("seg%0d_lat%0d_writes", s, lat_tab[v]), n_we, 15);
                    check($sformatf("seg%0d_lat%0d_reads", s, lat_tab[v]), n_rd, 5);
                    check($sformatf("seg%0d_lat%0d_results", s, lat_tab[v]), n_ov, e_ov);
                    check($sformatf("seg%0d_lat%0d_clears", s, lat_tab[v]), n_clr, 1);
                    check($sformatf("seg%0d_lat%0d_done", s, lat_tab[v]), n_done, 0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
